// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: default widths and the fetch queue entry payload.
package cpu_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned FETCH_DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear; push while full is accepted only
// together with a pop, pop while empty is ignored.
module sync_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push_c, do_pop_c;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    do_pop_c  = pop_i && !empty_o;
    do_push_c = push_i && (!full_o || do_pop_c);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push_c) - CW'(do_pop_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; validity is tracked by the counter.
  always_ff @(posedge clk) begin
    if (do_push_c && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue with credit-based request issue and flush discard.
// Optional macro FETCH_QUEUE_BYPASS_EN: responses to an empty queue reach decode same cycle.
module fetch_queue #(
  parameter int unsigned DEPTH = cpu_pkg::FETCH_DEPTH,
  parameter int unsigned XLEN  = cpu_pkg::XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  output logic            stall_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            dec_valid,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc,
  input  logic            dec_ready
);

  localparam int unsigned CW = cpu_pkg::cnt_width(DEPTH);
  localparam int unsigned EW = 2 * XLEN;

  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   q_count, t_count, used_c;
  logic [EW-1:0]   q_rdata;
  logic [XLEN-1:0] tag_head;
  logic            q_empty, q_full, t_empty, t_full;
  logic            accept_c, rsp_live_c, q_push_c, q_pop_c;

  assign imem_req_addr = pc;

  // Credit check, request issue and response routing.
  always_comb begin
    used_c         = q_count + inflight_q;
    imem_req_valid = i_rst && !flush && (used_c < CW'(DEPTH)) && !t_full;
    accept_c       = imem_req_valid && imem_req_ready;
    stall_pc       = !(i_rst && (accept_c || flush));
    rsp_live_c     = i_rst && imem_rsp_valid && !flush && (discard_q == '0) && !t_empty;
    q_pop_c        = !q_empty && dec_ready;
`ifdef FETCH_QUEUE_BYPASS_EN
    dec_valid = !q_empty || rsp_live_c;
    dec_pc    = q_empty ? tag_head      : q_rdata[EW-1:XLEN];
    dec_instr = q_empty ? imem_rsp_data : q_rdata[XLEN-1:0];
    q_push_c  = rsp_live_c && !(q_empty && dec_ready) && (!q_full || q_pop_c);
`else
    dec_valid = !q_empty;
    dec_pc    = q_rdata[EW-1:XLEN];
    dec_instr = q_rdata[XLEN-1:0];
    q_push_c  = rsp_live_c && (!q_full || q_pop_c);
`endif
  end

  // Discarded responses are still in flight, so inflight alone returns credit.
  always_comb begin
    inflight_d = inflight_q + CW'(accept_c) - CW'(imem_rsp_valid);
    discard_d  = discard_q;
    if (flush) begin
      discard_d = discard_q + t_count - CW'(imem_rsp_valid);
    end else if (imem_rsp_valid && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_queue (
    .clk     (i_clk),
    .rst_n   (i_rst),
    .clear_i (flush),
    .push_i  (q_push_c),
    .pop_i   (q_pop_c),
    .wdata_i ({tag_head, imem_rsp_data}),
    .rdata_o (q_rdata),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tags (
    .clk     (i_clk),
    .rst_n   (i_rst),
    .clear_i (flush),
    .push_i  (accept_c),
    .pop_i   (rsp_live_c),
    .wdata_i (pc),
    .rdata_o (tag_head),
    .full_o  (t_full),
    .empty_o (t_empty),
    .count_o (t_count)
  );

endmodule
